// File: rtl/bcd_pkg.sv
// Shared types and helpers for the iterative binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  // Minimum number of decimal digits needed to show the largest w-bit value.
  function automatic int bcd_digits(int w);
    longint max_val;
    longint pow10;
    int     digits;
    max_val = (longint'(1) << w) - 1;
    pow10   = 10;
    digits  = 1;
    while (pow10 <= max_val) begin
      pow10  = pow10 * 10;
      digits = digits + 1;
    end
    return digits;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step: values of five or more get +3 so the
// following left shift carries properly into the next decimal digit.
module bcd_digit_adj (
  input  logic [3:0] d_in,
  output logic [3:0] d_out
);

  // Add-3 correction, kept within the 4-bit digit (no carry out).
  always_comb begin
    d_out = (d_in >= 4'd5) ? d_in + 4'd3 : d_in;
  end

endmodule

// File: rtl/bcd_conv_secuencial.sv
// Sequential binary-to-BCD converter (double dabble). A word is taken over a
// valid/ready handshake, W_BIN correct-and-shift iterations run one per cycle,
// and the packed BCD result is presented until the consumer takes it.
module bcd_conv_secuencial
  import bcd_pkg::*;
#(
  parameter int W_BIN = 8,
  parameter int N_DIG = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W_BIN-1:0]   bin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*N_DIG-1:0] bcd,
  output logic               busy
);

  localparam int BW = 4 * N_DIG;
  localparam int CW = (W_BIN > 1) ? $clog2(W_BIN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W_BIN - 1);

  if (N_DIG < bcd_digits(W_BIN)) begin : g_bad_digits
    $error("bcd_conv_secuencial: N_DIG=%0d too small for W_BIN=%0d", N_DIG, W_BIN);
  end

  bcd_state_t          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [W_BIN-1:0]    bin_q, bin_d;
  logic [BW-1:0]       acc_q, acc_d;
  logic [BW-1:0]       res_q, res_d;
  logic [BW-1:0]       acc_adj;
  logic [BW+W_BIN-1:0] cat_shift;

  // Every digit of the working register is corrected in parallel.
  for (genvar g = 0; g < N_DIG; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_in  (acc_q[4*g +: 4]),
      .d_out (acc_adj[4*g +: 4])
    );
  end

  // Corrected digits and remaining binary bits shift left together.
  always_comb begin
    cat_shift = {acc_adj, bin_q} << 1;
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    acc_d     = acc_q;
    res_d     = res_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          bin_d   = bin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy  = 1'b1;
        acc_d = cat_shift[BW+W_BIN-1:W_BIN];
        bin_d = cat_shift[W_BIN-1:0];
        if (cnt_q == CNT_LAST) begin
          res_d   = cat_shift[BW+W_BIN-1:W_BIN];
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  assign bcd = res_q;

endmodule

// File: tb/tb_bcd_conv_secuencial.sv
// Directed bench for bcd_conv_secuencial: 8-bit/3-digit and 4-bit/2-digit builds.
module tb_bcd_conv_secuencial;

  logic        clk;
  logic        rst;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  bin8;
  logic [11:0] bcd8;

  logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [3:0]  bin4;
  logic [7:0]  bcd4;

  int checks;
  int passes;

  bcd_conv_secuencial #(.W_BIN(8), .N_DIG(3)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .bin       (bin8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .bcd       (bcd8),
    .busy      (busy8)
  );

  bcd_conv_secuencial #(.W_BIN(4), .N_DIG(2)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .bin       (bin4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .bcd       (bcd4),
    .busy      (busy4)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by division, independent of double dabble.
  function automatic logic [11:0] refBcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one word to the 8-bit converter, return its result and the number
  // of edges from the accepting edge (counted as 1) until out_valid is seen.
  task automatic applyStimulus(input logic [7:0] v, output logic [11:0] res, output int lat);
    int guard;
    in_valid8 = 1'b1;
    bin8      = v;
    guard     = 0;
    while (!in_ready8 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bcd8;
  endtask

  // Back-to-back stream 0..n-1 with random consumer stalls; sel picks the 4-bit build.
  task automatic runExhaustive(input bit sel, input int n);
    int          q[$];
    int          next_v;
    int          got;
    int          cyc;
    logic        iv, ir, ov, orr;
    logic [11:0] obs;
    logic [11:0] r;
    next_v = 0;
    got    = 0;
    cyc    = 0;
    while (got < n && cyc < 20000) begin
      if (sel) begin
        in_valid4  = (next_v < n);
        bin4       = 4'(next_v);
        out_ready4 = 1'($urandom_range(0, 1));
        iv = in_valid4; ir = in_ready4; ov = out_valid4; orr = out_ready4;
        obs = {4'h0, bcd4};
      end else begin
        in_valid8  = (next_v < n);
        bin8       = 8'(next_v);
        out_ready8 = 1'($urandom_range(0, 1));
        iv = in_valid8; ir = in_ready8; ov = out_valid8; orr = out_ready8;
        obs = bcd8;
      end
      if (iv && ir) begin
        q.push_back(next_v);
        next_v++;
      end
      if (ov && orr) begin
        if (q.size() == 0) begin
          checkOutput("exh_spurious", 32'd1, 32'd0);
        end else begin
          r = refBcd(q.pop_front());
          if (sel) r[11:8] = 4'h0;
          checkOutput(sel ? "exh4_bcd" : "exh8_bcd", {20'd0, obs}, {20'd0, r});
        end
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput(sel ? "exh4_count" : "exh8_count", got, n);
    in_valid4  = 1'b0;
    in_valid8  = 1'b0;
    out_ready4 = 1'b1;
    out_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Directed sequence followed by the exhaustive sweeps.
  initial begin
    logic [11:0] res;
    int          lat;
    int          spurious;
    checks     = 0;
    passes     = 0;
    rst        = 1'b1;
    in_valid8  = 1'b0; bin8 = 8'd0; out_ready8 = 1'b1;
    in_valid4  = 1'b0; bin4 = 4'd0; out_ready4 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("reset_in_ready", in_ready8, 1);
    checkOutput("reset_out_valid", out_valid8, 0);
    checkOutput("reset_busy", busy8, 0);
    checkOutput("reset_bcd", bcd8, 0);

    // Zero input, latency and return to IDLE.
    applyStimulus(8'd0, res, lat);
    checkOutput("zero_bcd", res, 12'h000);
    checkOutput("zero_latency", lat, 9);
    checkOutput("zero_in_ready_done", in_ready8, 0);
    @(posedge clk); #1;
    checkOutput("zero_back_idle", {out_valid8, in_ready8}, 2'b01);

    // Boundary values.
    applyStimulus(8'd255, res, lat);
    checkOutput("bcd_255", res, 12'h255);
    checkOutput("lat_255", lat, 9);
    applyStimulus(8'd99, res, lat);
    checkOutput("bcd_99", res, 12'h099);
    applyStimulus(8'd100, res, lat);
    checkOutput("bcd_100", res, 12'h100);
    @(posedge clk); #1;

    // Backpressure holds the result.
    out_ready8 = 1'b0;
    applyStimulus(8'd137, res, lat);
    checkOutput("bp_bcd", res, 12'h137);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_hold", {out_valid8, in_ready8, bcd8}, {1'b1, 1'b0, 12'h137});
    end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release", {out_valid8, in_ready8}, 2'b01);

    // New word offered during SHIFT is ignored until IDLE.
    in_valid8 = 1'b1;
    bin8      = 8'd7;
    @(posedge clk); #1;
    bin8 = 8'd42;
    checkOutput("busy_shift", busy8, 1);
    checkOutput("bcd_hold_in_shift", bcd8, 12'h137);
    lat = 1;
    while (!out_valid8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("ovl_lat", lat, 9);
    checkOutput("ovl_bcd_7", bcd8, 12'h007);
    checkOutput("ovl_no_accept_done", in_ready8, 0);
    @(posedge clk); #1;
    checkOutput("ovl_idle_not_taken", {out_valid8, busy8, in_ready8}, 3'b001);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    checkOutput("ovl_42_taken", busy8, 1);
    lat = 1;
    while (!out_valid8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("ovl_bcd_42", bcd8, 12'h042);
    @(posedge clk); #1;

    // Reset during iteration 4 of 200 aborts the conversion.
    in_valid8 = 1'b1;
    bin8      = 8'd200;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("abort_busy_before", busy8, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort_state", {in_ready8, out_valid8, busy8}, 3'b100);
    checkOutput("abort_bcd", bcd8, 12'h000);
    spurious = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid8 || busy8) spurious++;
    end
    checkOutput("abort_no_spurious", spurious, 0);

    runExhaustive(1'b0, 256);
    runExhaustive(1'b1, 16);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
